// File: rtl/periph_bus_arbiter.sv
// ---------------------------------------------------------------------------
// periph_bus_arbiter
//
// Purpose:
//   Two-master, single-slave arbiter for the peripheral bus. Master 0 is the
//   CPU MEM stage and master 1 is the debug/DMA loader. Each granted
//   transaction walks IDLE -> ACCESS -> RESP -> IDLE. The request is sampled
//   in IDLE, the peripheral is strobed for one cycle in ACCESS, and the ack
//   pulse is issued in RESP. When both masters request at once, the master
//   that was not granted last wins, so the two masters strictly alternate
//   under continuous contention.
//
// Optional feature (macro ARB_LOCK_EN):
//   Adds m0_lock/m1_lock inputs. If the owner holds lock high during its RESP
//   cycle, the bus stays reserved for that master. The reservation lasts
//   until an IDLE cycle sees the owner's lock or req low.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   m0_req/we/addr/wdata    master 0 request, direction, address, write data
//   m0_ack, m0_rdata        master 0 one-cycle completion pulse, read data
//   m1_*                    same set for master 1
//   m0_lock, m1_lock        bus-lock requests (ARB_LOCK_EN only)
//   s_read, s_write         peripheral MemRead / MemWrite strobes
//   s_addr, s_wdata         peripheral address / write data (held when idle)
//   s_rdata                 peripheral read data, combinational from s_addr
//   owner                   index of the master holding the bus
// ---------------------------------------------------------------------------
module periph_bus_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
`ifdef ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_lastGrant;
    logic        r_we;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_anyReq;
    logic        w_grant;

`ifdef ARB_LOCK_EN
    logic        r_locked;
    logic        w_ownerReq;
    logic        w_ownerLock;
    logic        w_lockHold;
`endif

    // Winner selection for the IDLE cycle. A lone requester always wins; on
    // a tie the master that did not win last time gets the bus. With locking
    // enabled, a still-locked owner that keeps requesting overrides this.
    always_comb begin
        w_anyReq = m0_req | m1_req;
        w_grant  = 1'b0;
        if (m0_req && m1_req) begin
            w_grant = ~r_lastGrant;
        end else begin
            w_grant = m1_req;
        end
`ifdef ARB_LOCK_EN
        w_ownerReq  = r_owner ? m1_req  : m0_req;
        w_ownerLock = r_owner ? m1_lock : m0_lock;
        w_lockHold  = r_locked & w_ownerReq & w_ownerLock;
        if (w_lockHold) begin
            w_grant = r_owner;
        end
`endif
    end

    // Main FSM. Every output is a register, so the strobes line up exactly
    // with ACCESS and the ack with RESP. Ack and rdata default to zero every
    // cycle, which keeps them a single-cycle pulse. The address and write
    // data registers are only loaded on a grant, so they hold between
    // transactions. Reset is asynchronous, so it kills a strobe in flight
    // at once, and the aborted transaction never reaches RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_we        <= 1'b0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_rdata0    <= 32'h0;
            r_rdata1    <= 32'h0;
`ifdef ARB_LOCK_EN
            r_locked    <= 1'b0;
`endif
        end else begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
`ifdef ARB_LOCK_EN
                    if (r_locked && !w_lockHold) begin
                        r_locked <= 1'b0;
                    end
`endif
                    if (w_anyReq) begin
                        r_state     <= ST_ACCESS;
                        r_owner     <= w_grant;
                        r_lastGrant <= w_grant;
                        r_we        <= w_grant ? m1_we    : m0_we;
                        r_addr      <= w_grant ? m1_addr  : m0_addr;
                        r_wdata     <= w_grant ? m1_wdata : m0_wdata;
                        r_write     <= w_grant ? m1_we    : m0_we;
                        r_read      <= w_grant ? ~m1_we   : ~m0_we;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_RESP;
                    if (r_owner) begin
                        r_ack1   <= 1'b1;
                        r_rdata1 <= r_we ? 32'h0 : s_rdata;
                    end else begin
                        r_ack0   <= 1'b1;
                        r_rdata0 <= r_we ? 32'h0 : s_rdata;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
`ifdef ARB_LOCK_EN
                    if (w_ownerLock) begin
                        r_locked <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_read   = r_read;
    assign s_write  = r_write;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign m0_ack   = r_ack0;
    assign m1_ack   = r_ack1;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign owner    = r_owner;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_periph_bus_arbiter
//
// Purpose:
//   Directed, self-checking bench for periph_bus_arbiter. Single
//   transactions come from a table of hand-computed records. Round-robin
//   ordering, reset abort and lock behaviour are written out as sequences.
//   The peripheral is modelled as a small combinational read decoder.
//   Build with ARB_LOCK_EN defined to exercise the lock ports.
// ---------------------------------------------------------------------------
module tb_periph_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
`ifdef ARB_LOCK_EN
    logic        m0_lock;
    logic        m1_lock;
`endif
    logic        s_read;
    logic        s_write;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        owner;

    int checks = 0;
    int errors = 0;

    logic grantOrder [0:7];
    int   ackCycle   [0:7];
    int   grantCount;

    typedef struct {
        logic        master;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        expRead;
        logic        expWrite;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vectors [0:3];

    periph_bus_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
`ifdef ARB_LOCK_EN
        .m0_lock  (m0_lock),
        .m1_lock  (m1_lock),
`endif
        .s_read   (s_read),
        .s_write  (s_write),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .owner    (owner)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral model: a couple of readable registers, everything else
    // returns a recognisable filler pattern. Data only while s_read is high.
    function automatic logic [31:0] periphRead(input logic [31:0] addr);
        case (addr)
            32'h4000_0014: periphRead = 32'h0000_1234;
            32'h4000_0020: periphRead = 32'hCAFE_F00D;
            default:       periphRead = 32'hBAD0_BAD0;
        endcase
    endfunction

    assign s_rdata = s_read ? periphRead(s_addr) : 32'h0;

    // Hard stop in case some wait goes wrong; never reached in a healthy run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected done", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Runs one isolated transaction from IDLE and checks the ACCESS cycle,
    // the RESP cycle and the return to IDLE. Entered and left on a negedge.
    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        m0_req = 1'b0;
        m1_req = 1'b0;
        if (v.master) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        @(negedge clk);
        checkOutput({tag, " access s_write"}, {31'b0, s_write}, {31'b0, v.expWrite});
        checkOutput({tag, " access s_read"},  {31'b0, s_read},  {31'b0, v.expRead});
        checkOutput({tag, " access s_addr"},  s_addr,  v.addr);
        checkOutput({tag, " access s_wdata"}, s_wdata, v.wdata);
        checkOutput({tag, " access owner"},   {31'b0, owner}, {31'b0, v.master});
        checkOutput({tag, " access acks"},    {30'b0, m1_ack, m0_ack}, 32'h0);
        @(negedge clk);
        checkOutput({tag, " resp m0_ack"},   {31'b0, m0_ack}, {31'b0, ~v.master});
        checkOutput({tag, " resp m1_ack"},   {31'b0, m1_ack}, {31'b0, v.master});
        checkOutput({tag, " resp m0_rdata"}, m0_rdata, v.master ? 32'h0 : v.expRdata);
        checkOutput({tag, " resp m1_rdata"}, m1_rdata, v.master ? v.expRdata : 32'h0);
        checkOutput({tag, " resp strobes"},  {30'b0, s_read, s_write}, 32'h0);
        checkOutput({tag, " resp s_addr"},   s_addr, v.addr);
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        checkOutput({tag, " idle acks"},    {30'b0, m1_ack, m0_ack}, 32'h0);
        checkOutput({tag, " idle strobes"}, {30'b0, s_read, s_write}, 32'h0);
        checkOutput({tag, " idle s_addr"},  s_addr,  v.addr);
        checkOutput({tag, " idle s_wdata"}, s_wdata, v.wdata);
    endtask

    // Drives both masters as request/ack state machines and records which
    // master each ack went to, and in which cycle. Cycle 1 is the cycle in
    // which the first request is presented. A master renews its request
    // while it still has transactions left.
    task automatic runGrants(input int n0, input int n1, input int delay0, input bit useLock, input int nRecord);
        int rem0;
        int rem1;
        bit done;
        rem0 = n0;
        rem1 = n1;
        done = 1'b0;
        grantCount = 0;
        for (int k = 0; k < 8; k++) begin
            grantOrder[k] = 1'bx;
            ackCycle[k]   = -1;
        end
        for (int c = 1; c <= 60 && !done; c++) begin
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                checkOutput($sformatf("single ack cycle %0d", c), {31'b0, m0_ack & m1_ack}, 32'h0);
                if (grantCount < 8) begin
                    grantOrder[grantCount] = m1_ack;
                    ackCycle[grantCount]   = c;
                end
                grantCount++;
                if (m0_ack && rem0 > 0) rem0--;
                if (m1_ack && rem1 > 0) rem1--;
                if (grantCount >= nRecord) done = 1'b1;
            end
            m0_req = !done && (rem0 > 0) && (c > delay0);
            m1_req = !done && (rem1 > 0);
`ifdef ARB_LOCK_EN
            m1_lock = useLock && !done && (rem1 > 0);
`endif
            @(negedge clk);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
`ifdef ARB_LOCK_EN
        m1_lock = 1'b0;
`endif
        if (grantCount < nRecord) begin
            checks++;
            errors++;
            $display("[TB] FAIL grant timeout: got %0d acks, expected %0d", grantCount, nRecord);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic expOrder [0:3];

        vectors[0] = '{master: 1'b0, we: 1'b1, addr: 32'h4000_000C, wdata: 32'h0000_00A5,
                       expRead: 1'b0, expWrite: 1'b1, expRdata: 32'h0};
        vectors[1] = '{master: 1'b1, we: 1'b0, addr: 32'h4000_0014, wdata: 32'h1111_1111,
                       expRead: 1'b1, expWrite: 1'b0, expRdata: 32'h0000_1234};
        vectors[2] = '{master: 1'b1, we: 1'b1, addr: 32'h4000_0020, wdata: 32'hDEAD_BEEF,
                       expRead: 1'b0, expWrite: 1'b1, expRdata: 32'h0};
        vectors[3] = '{master: 1'b0, we: 1'b0, addr: 32'h4000_0020, wdata: 32'h2222_2222,
                       expRead: 1'b1, expWrite: 1'b0, expRdata: 32'hCAFE_F00D};

        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
`ifdef ARB_LOCK_EN
        m0_lock = 1'b0;
        m1_lock = 1'b0;
`endif

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("reset s_read",   {31'b0, s_read},  32'h0);
        checkOutput("reset s_write",  {31'b0, s_write}, 32'h0);
        checkOutput("reset s_addr",   s_addr,   32'h0);
        checkOutput("reset s_wdata",  s_wdata,  32'h0);
        checkOutput("reset acks",     {30'b0, m1_ack, m0_ack}, 32'h0);
        checkOutput("reset m0_rdata", m0_rdata, 32'h0);
        checkOutput("reset m1_rdata", m1_rdata, 32'h0);
        checkOutput("reset owner",    {31'b0, owner}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both masters hold requests from reset: m0 wins first, then alternate.
        m0_we = 1'b1; m0_addr = 32'h4000_0100; m0_wdata = 32'h0000_0001;
        m1_we = 1'b1; m1_addr = 32'h4000_0200; m1_wdata = 32'h0000_0002;
        runGrants(2, 2, 0, 1'b0, 4);
        expOrder[0] = 1'b0; expOrder[1] = 1'b1; expOrder[2] = 1'b0; expOrder[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("rr grant %0d", k), {31'b0, grantOrder[k]}, {31'b0, expOrder[k]});
            checkOutput($sformatf("rr ack cycle %0d", k), ackCycle[k], 3 * (k + 1));
        end

        // Isolated single transactions; the last record leaves m0 as last grant.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, vectors[i]);
        end

        // Reset in the middle of an m0 read: strobe dies at once, no ack,
        // and the first tie after release goes to m0 again.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4000_0014; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h4000_0020;
        @(negedge clk);
        checkOutput("abort pre s_read", {31'b0, s_read}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort strobes", {30'b0, s_read, s_write}, 32'h0);
        checkOutput("abort s_addr",  s_addr, 32'h0);
        m1_req = 1'b1;
        @(negedge clk);
        checkOutput("abort no ack", {30'b0, m1_ack, m0_ack}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post-reset owner",  {31'b0, owner},  32'h0);
        checkOutput("post-reset s_read", {31'b0, s_read}, 32'h1);
        @(negedge clk);
        checkOutput("post-reset m0_ack",   {31'b0, m0_ack}, 32'h1);
        checkOutput("post-reset m1_ack",   {31'b0, m1_ack}, 32'h0);
        checkOutput("post-reset m0_rdata", m0_rdata, 32'h0000_1234);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) @(negedge clk);

        // m1 starts alone and wants three writes, m0 joins a cycle later.
        // With the lock feature m1 keeps the bus for all three.
        resetDut();
        m0_we = 1'b1; m0_addr = 32'h4000_0300; m0_wdata = 32'h0000_0030;
        m1_we = 1'b1; m1_addr = 32'h4000_0400; m1_wdata = 32'h0000_0040;
        runGrants(2, 3, 1, 1'b1, 4);
`ifdef ARB_LOCK_EN
        expOrder[0] = 1'b1; expOrder[1] = 1'b1; expOrder[2] = 1'b1; expOrder[3] = 1'b0;
`else
        expOrder[0] = 1'b1; expOrder[1] = 1'b0; expOrder[2] = 1'b1; expOrder[3] = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("lock grant %0d", k), {31'b0, grantOrder[k]}, {31'b0, expOrder[k]});
            checkOutput($sformatf("lock ack cycle %0d", k), ackCycle[k], 3 * (k + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 SHALL have ports, one per line:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_req  in  1  master 0 (CPU MEM stage) transaction request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  32  master 0 peripheral address.
- m0_wdata  in  32  master 0 write data.
- m0_ack  out  1  master 0 transaction complete, one-cycle pulse.
- m0_rdata  out  32  master 0 read data, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same widths and meanings for master 1 (debug/DMA loader).
- m0_lock, m1_lock  in  1  bus-lock request (present only with ARB_LOCK_EN).
- s_read  out  1  peripheral MemRead strobe.
- s_write  out  1  peripheral MemWrite strobe.
- s_addr  out  32  peripheral Address.
- s_wdata  out  32  peripheral WriteData.
- s_rdata  in  32  peripheral ReadData (combinational from s_addr/s_read).
- owner  out  1  index of master holding the bus in ACCESS/RESP.

Function
REQ-002 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; every granted transaction takes exactly 3 cycles from the IDLE cycle in which req is sampled to the ack cycle.
REQ-003 In IDLE: no req -> stay IDLE; one req -> grant it; both -> grant the master not in last_grant (round-robin); owner and last_grant register the winner on the exiting edge.
REQ-004 On the IDLE->ACCESS edge, owner's we/addr/wdata SHALL be registered; master SHALL hold them stable until its ack.
REQ-005 In ACCESS: s_addr/s_wdata = registered values; s_write = we, s_read = ~we, for exactly one cycle; s_rdata captured at end of cycle.
REQ-006 In RESP: owner's ack = 1 for one cycle, its rdata = captured s_rdata (0 for writes); non-owner ack = 0, rdata = 0.
REQ-007 Outside ACCESS, s_read = s_write = 0; s_addr and s_wdata SHALL hold last values.
REQ-008 Master SHALL drop or renew req in the cycle after ack; req high in IDLE is always a new request (back-to-back from one master allowed, one per 3 cycles).
REQ-009 Non-owner req arriving during ACCESS/RESP SHALL wait; no request is ever lost while req held high.
REQ-010 Starvation bound: with both masters continuously requesting, grants SHALL strictly alternate (max wait 6 cycles).

Reset
REQ-011 rst_n low SHALL immediately force IDLE, owner=0, last_grant=1 (m0 wins first tie), s_read=s_write=0, s_addr=s_wdata=0, acks=0, rdatas=0, lock state cleared.
REQ-012 Reset during ACCESS SHALL abort the strobe the same instant; no ack issued for the aborted transaction.

Configuration
REQ-013 Macro ARB_LOCK_EN: when defined, lock ports exist; if owner's lock=1 during its RESP cycle, locked flag sets and IDLE grants only that master (other held off) until IDLE sees owner lock=0 or req=0, which clears the flag and resumes round-robin.
REQ-014 Without ARB_LOCK_EN: lock ports and locked flag absent; pure round-robin per REQ-003.

Verification
REQ-015 m0 write addr 0x4000000C data 0x000000A5 alone -> s_write=1 exactly cycle 2, s_addr=0x4000000C, s_wdata=0xA5, m0_ack cycle 3, m1_ack stays 0.
REQ-016 m1 read 0x40000014 with s_rdata=0x00001234 -> s_read one cycle, m1_ack with m1_rdata=0x00001234, m0_rdata=0.
REQ-017 Both req simultaneously after reset, held 4 transactions -> grant order m0,m1,m0,m1; acks at cycles 3,6,9,12.
REQ-018 rst_n asserted mid-ACCESS -> s_read/s_write drop same cycle, no ack, first tie after release goes to m0.
REQ-019 ARB_LOCK_EN: m1 locked, 3 back-to-back writes while m0 requests -> m1,m1,m1 then m0 after m1_lock=0; without macro -> m1,m0,m1,m0.
